// File: rtl/cpu_cycle_sequencer.sv
// cpu_cycle_sequencer
//   Instruction-cycle controller for the 16-bit CPU core. It steps each
//   instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives
//   the memory-bus handshake, the IR/PC strobes and the register write enable.
//   A memory request that is not acknowledged within MEM_TIMEOUT cycles parks
//   the core in ERR. A decoded HALT parks it in HALT. Only reset leaves either.
//
// Parameters
//   MEM_TIMEOUT  cycles with mem_req=1 and no mem_ack before a bus error (1..255)
//
// Ports
//   clk          in   rising-edge system clock
//   reset        in   asynchronous, active-low reset
//   run          in   1 = execute, 0 = stop at the next instruction boundary
//   mem_ack      in   memory completes the current request (FETCH/MEM only)
//   dec_mem      in   decoded instruction needs a data-memory access
//   dec_store    in   data access is a write
//   dec_wb       in   decoded instruction writes the register file
//   dec_halt     in   decoded instruction is HALT
//   irq          in   level interrupt request            (CPU_SEQ_IRQ_EN only)
//   irq_ack      out  interrupt taken at this retire     (CPU_SEQ_IRQ_EN only)
//   vec_load     out  load PC from the interrupt vector  (CPU_SEQ_IRQ_EN only)
//   icycle       out  current state encoding
//   mem_req      out  memory request
//   mem_we       out  memory write strobe
//   mem_sel      out  address source: 0 = PC, 1 = data address
//   ir_load      out  load instruction register from the bus
//   pc_inc       out  increment PC
//   reg_we       out  register-file write enable
//   halted       out  core halted
//   bus_err      out  memory timeout occurred
//   instr_count  out  retired-instruction counter (wraps)
//
// Configuration
//   CPU_SEQ_IRQ_EN  adds the interrupt ports and takes irq at retire.
module cpu_cycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        mem_ack,
  input  logic        dec_mem,
  input  logic        dec_store,
  input  logic        dec_wb,
  input  logic        dec_halt,
`ifdef CPU_SEQ_IRQ_EN
  input  logic        irq,
  output logic        irq_ack,
  output logic        vec_load,
`endif
  output logic [2:0]  icycle,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        reg_we,
  output logic        halted,
  output logic        bus_err,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic [7:0]  wait_inc;
  logic        retire;

  assign wait_inc = wait_q + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Outputs decode from state_q (plus mem_ack for the fetch strobes), so
  // they drop as soon as reset forces state_q back to IDLE.
  // wait_d defaults to zero, so the counter is already clear on every entry
  // to FETCH or MEM. It only counts cycles that see no acknowledge.
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    instr_count_d = instr_count_q;
    retire        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_sel       = 1'b0;
    ir_load       = 1'b0;
    pc_inc        = 1'b0;
    reg_we        = 1'b0;
    halted        = 1'b0;
    bus_err       = 1'b0;
`ifdef CPU_SEQ_IRQ_EN
    irq_ack       = 1'b0;
    vec_load      = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT) state_d = S_ERR;
        end
      end
      S_DECODE: begin
        state_d = dec_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (dec_mem)     state_d = S_MEM;
        else if (dec_wb) state_d = S_WB;
        else             retire  = 1'b1;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = dec_store;
        if (mem_ack) begin
          if (dec_wb) state_d = S_WB;
          else        retire  = 1'b1;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT) state_d = S_ERR;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        retire = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERR: begin
        bus_err = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Retiring overrides the per-state next state. This is the only place
    // the counter advances and the only point where an interrupt is taken.
    if (retire) begin
      instr_count_d = instr_count_q + 16'd1;
      state_d       = run ? S_FETCH : S_IDLE;
`ifdef CPU_SEQ_IRQ_EN
      if (run && irq) begin
        irq_ack  = 1'b1;
        vec_load = 1'b1;
      end
`endif
    end
  end

  assign icycle      = state_q;
  assign instr_count = instr_count_q;

endmodule
